// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the initiator and future Wishbone blocks.
//   DAT_WIDTH : Wishbone data bus width
//   SEL_WIDTH : Wishbone byte-select width
//   wb_state_e: initiator sequencing states
package wb_pkg;

  localparam int DAT_WIDTH = 32;
  localparam int SEL_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_timeout.sv
// Bus-cycle timeout timer.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   clr_i     : reload the timer at the start of a bus cycle
//   en_i      : count one waited cycle
//   expired_o : the current cycle is the TIMEOUT-th waited cycle
// Implemented as a down-counter loaded with TIMEOUT-1 that flags at zero,
// which is equivalent to an up-counter compared against TIMEOUT-1.
// TIMEOUT = 0 disables the timer: expired_o never asserts.
module wb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt <= LOAD;
    end else if (en_i && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired_o = (TIMEOUT != 0) && (cnt == '0);

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: one single-beat command in, one bus cycle out,
// one response (read data or timeout error) back. One transaction in flight.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   cmd_*                   : valid/ready command port (adr, we, sel, dat)
//   rsp_*                   : valid/ready response port (dat, err)
//   cyc_o/stb_o/we_o/adr_o/sel_o/dat_o, dat_i/ack_i : Wishbone initiator side
//
// state | meaning
// IDLE  | ready for a command, bus idle
// BUS   | cyc/stb asserted, waiting for ack_i or timeout
// RESP  | response held on rsp_* until the consumer takes it
module wb_initiator
  import wb_pkg::*;
#(
  parameter int ADR_WIDTH = 30,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [ADR_WIDTH-1:0] cmd_adr_i,
  input  logic                 cmd_we_i,
  input  logic [SEL_WIDTH-1:0] cmd_sel_i,
  input  logic [DAT_WIDTH-1:0] cmd_dat_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DAT_WIDTH-1:0] rsp_dat_o,
  output logic                 rsp_err_o,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic                 we_o,
  output logic [ADR_WIDTH-1:0] adr_o,
  output logic [SEL_WIDTH-1:0] sel_o,
  output logic [DAT_WIDTH-1:0] dat_o,
  input  logic [DAT_WIDTH-1:0] dat_i,
  input  logic                 ack_i
);

  wb_state_e state;
  logic      accept;
  logic      expired;

  assign cmd_ready_o = (state == IDLE);
  assign accept      = cmd_valid_i && cmd_ready_o;

  wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (accept),
    .en_i     ((state == BUS) && !ack_i),
    .expired_o(expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      we_o        <= 1'b0;
      adr_o       <= '0;
      sel_o       <= '0;
      dat_o       <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            adr_o <= cmd_adr_i;
            we_o  <= cmd_we_i;
            sel_o <= cmd_sel_i;
            dat_o <= cmd_dat_i;
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            state <= BUS;
          end
        end
        BUS: begin
          // ack has priority over a timeout landing in the same cycle
          if (ack_i) begin
            rsp_dat_o   <= we_o ? '0 : dat_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            state       <= RESP;
          end else if (expired) begin
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          cyc_o       <= 1'b0;
          stb_o       <= 1'b0;
          rsp_valid_o <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
module tb_wb_initiator;

  localparam int AW = 30;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_adr = '0;
  logic          cmd_we = 1'b0;
  logic [3:0]    cmd_sel = '0;
  logic [31:0]   cmd_dat = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_dat;
  logic          rsp_err;
  logic          cyc, stb, we;
  logic [AW-1:0] adr;
  logic [3:0]    sel;
  logic [31:0]   dat_o, dat_i;
  logic          ack;

  // parallel-port style responder: word 0 = output register, word 1 = input pins
  logic [31:0] parallel_o = '0;
  logic [31:0] parallel_i = '0;
  int          wait_n = 0;
  bit          no_ack = 1'b0;
  bit          ack_extra = 1'b0;
  int          bus_cnt = 0;
  logic        slave_ack;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wb_initiator #(.ADR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_adr_i(cmd_adr),
    .cmd_we_i(cmd_we), .cmd_sel_i(cmd_sel), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .sel_o(sel),
    .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack)
  );

  assign slave_ack = cyc && stb && !no_ack && (bus_cnt == wait_n);
  assign ack       = slave_ack || ack_extra;
  assign dat_i     = adr[0] ? parallel_i : parallel_o;

  always @(posedge clk) begin
    if (cyc && stb && !ack) bus_cnt <= bus_cnt + 1;
    else bus_cnt <= 0;
    if (slave_ack && we && !adr[0]) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) parallel_o[8*b +: 8] <= dat_o[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full command/response exchange with all checks; called at #1 after an edge in IDLE.
  task automatic run_txn(input logic [AW-1:0] a, input logic w_e, input logic [3:0] s,
                         input logic [31:0] d, input int w, input bit nack, input int rdy,
                         input logic [31:0] exp_dat, input bit exp_err, input int exp_lat,
                         input logic [31:0] exp_par);
    int cyc_n, stb_n;
    bit bus_ok, hold_ok;
    logic [31:0] got_dat;
    logic got_err;
    wait_n = w;
    no_ack = nack;
    cmd_adr = a; cmd_we = w_e; cmd_sel = s; cmd_dat = d;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    cyc_n = 0; stb_n = 0; bus_ok = 1'b1;
    while (!rsp_valid && cyc_n < 64) begin
      if (stb) begin
        stb_n++;
        if (adr !== a || we !== w_e || sel !== s || dat_o !== d || cmd_ready !== 1'b0 || cyc !== 1'b1)
          bus_ok = 1'b0;
      end
      tick();
      cyc_n++;
    end
    chk("rsp_latency", 32'(cyc_n + 1), 32'(exp_lat));
    chk("stb_cycles", 32'(stb_n), 32'(exp_lat - 1));
    chk("bus_stable", 32'(bus_ok), 32'd1);
    chk("rsp_dat", rsp_dat, exp_dat);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    got_dat = rsp_dat;
    got_err = rsp_err;
    // competing command and a stray ack while the response waits
    cmd_valid = 1'b1;
    cmd_adr = ~a;
    ack_extra = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < rdy; i++) begin
      if (rsp_valid !== 1'b1 || rsp_dat !== got_dat || rsp_err !== got_err ||
          cmd_ready !== 1'b0 || cyc !== 1'b0 || stb !== 1'b0)
        hold_ok = 1'b0;
      tick();
    end
    chk("rsp_hold", 32'(hold_ok), 32'd1);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    ack_extra = 1'b0;
    chk("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
    chk("parallel_o", parallel_o, exp_par);
  endtask

  typedef struct {
    logic [AW-1:0] adr;
    logic          we;
    logic [3:0]    sel;
    logic [31:0]   dat;
    int            w;
    bit            nack;
    int            rdy;
    logic [31:0]   pin;
    logic [31:0]   exp_dat;
    bit            exp_err;
    int            exp_lat;
    logic [31:0]   exp_par;
  } vec_t;

  vec_t vecs[8];

  logic [31:0] par_model;

  initial begin
    int acc, rv;
    vecs[0] = '{30'd0, 1'b1, 4'hF, 32'hDEADBEEF, 0, 1'b0, 0, 32'h0,        32'h0,        1'b0, 2, 32'hDEADBEEF};
    vecs[1] = '{30'd1, 1'b0, 4'hF, 32'h0,        0, 1'b0, 0, 32'h12345678, 32'h12345678, 1'b0, 2, 32'hDEADBEEF};
    vecs[2] = '{30'd0, 1'b1, 4'h4, 32'h00AA0000, 1, 1'b0, 1, 32'h0,        32'h0,        1'b0, 3, 32'hDEAABEEF};
    vecs[3] = '{30'd0, 1'b0, 4'hF, 32'h0,        2, 1'b0, 0, 32'h0,        32'hDEAABEEF, 1'b0, 4, 32'hDEAABEEF};
    vecs[4] = '{30'd0, 1'b0, 4'hF, 32'h0,        0, 1'b1, 2, 32'h0,        32'h0,        1'b1, 5, 32'hDEAABEEF};
    vecs[5] = '{30'd0, 1'b0, 4'hF, 32'h0,        3, 1'b0, 0, 32'h0,        32'hDEAABEEF, 1'b0, 5, 32'hDEAABEEF};
    vecs[6] = '{30'd0, 1'b1, 4'hF, 32'h11111111, 4, 1'b0, 0, 32'h0,        32'h0,        1'b1, 5, 32'hDEAABEEF};
    vecs[7] = '{30'd1, 1'b0, 4'hF, 32'h0,        0, 1'b0, 5, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 2, 32'hDEAABEEF};

    // reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_cyc", 32'(cyc), 32'd0);
    chk("reset_stb", 32'(stb), 32'd0);
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_adr", 32'(adr), 32'd0);
    chk("reset_sel", 32'(sel), 32'd0);
    chk("reset_dat", dat_o, 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_dat", rsp_dat, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);

    // directed vectors
    for (int i = 0; i < 8; i++) begin
      parallel_i = vecs[i].pin;
      run_txn(vecs[i].adr, vecs[i].we, vecs[i].sel, vecs[i].dat, vecs[i].w, vecs[i].nack,
              vecs[i].rdy, vecs[i].exp_dat, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_par);
    end

    // randomized transactions against a behavioural model of the exchange
    par_model = 32'hDEAABEEF;
    for (int t = 0; t < 40; t++) begin
      logic [AW-1:0] a;
      logic w_e;
      logic [3:0] s;
      logic [31:0] d, e_dat;
      int w, rdy, lat;
      bit nack, err;
      a    = AW'($urandom());
      w_e  = 1'($urandom_range(0, 1));
      s    = 4'($urandom_range(0, 15));
      d    = $urandom();
      w    = $urandom_range(0, 5);
      nack = ($urandom_range(0, 7) == 0);
      rdy  = $urandom_range(0, 3);
      parallel_i = $urandom();
      err  = nack || (w >= TO);
      lat  = err ? TO + 1 : w + 2;
      e_dat = (err || w_e) ? 32'h0 : (a[0] ? parallel_i : par_model);
      if (!err && w_e && !a[0])
        for (int b = 0; b < 4; b++)
          if (s[b]) par_model[8*b +: 8] = d[8*b +: 8];
      run_txn(a, w_e, s, d, w, nack, rdy, e_dat, err, lat, par_model);
    end

    // back-to-back throughput: ready tied high, zero-wait responder
    wait_n = 0; no_ack = 1'b0;
    parallel_i = 32'h0BADF00D;
    cmd_adr = 30'd1; cmd_we = 1'b0; cmd_sel = 4'hF;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    acc = 0; rv = 0;
    for (int i = 0; i < 12; i++) begin
      if (cmd_valid && cmd_ready) acc++;
      if (rsp_valid) rv++;
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    tick();
    rsp_ready = 1'b0;
    chk("throughput_accepts", 32'(acc), 32'd4);
    chk("throughput_rsps", 32'(rv), 32'd4);

    // reset in the middle of a bus cycle
    no_ack = 1'b1;
    cmd_adr = 30'h155; cmd_we = 1'b1; cmd_sel = 4'hA; cmd_dat = 32'h55AA55AA;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("midbus_stb", 32'(stb), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_cyc", 32'(cyc), 32'd0);
    chk("rst_mid_stb", 32'(stb), 32'd0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mid_adr", 32'(adr), 32'd0);
    chk("rst_mid_sel", 32'(sel), 32'd0);
    chk("rst_mid_dat", dat_o, 32'd0);
    chk("rst_mid_we", 32'(we), 32'd0);
    chk("rst_mid_rsp_err", 32'(rsp_err), 32'd0);
    tick();
    chk("rst_mid_idle_stays", 32'(cyc | stb | rsp_valid), 32'd0);
    // a full-length wait after reset must not be cut short by a stale timer
    parallel_i = 32'hA5A5A5A5;
    run_txn(30'd1, 1'b0, 4'hF, 32'h0, 3, 1'b0, 1, 32'hA5A5A5A5, 1'b0, 5, par_model);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
